wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the writeback stage
//   (priority) and the multiply/divide unit result path. The MDU is served in
//   cycles with no live writeback write. All register-file write controls are
//   registered, so a commit shows up on rf_* one cycle after its inputs.
//
//   Optional build macro: WB_STARVE_GUARD_EN
//     defined   - after MAX_WAIT blocked WAIT cycles a one-cycle STALL freezes
//                 the pipeline so the waiting MDU result can commit.
//     undefined - no STALL state, pipe_stall tied 0, wait_cnt saturates and
//                 the MDU waits indefinitely for a free cycle.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   wb_wren/wb_rd/wb_data : writeback-stage write request
//   mdu_valid/rd/data     : MDU result request
//   mdu_ready             : MDU result accepted this cycle (combinational)
//   pipe_stall            : freeze pipeline this cycle (combinational)
//   rf_wren/addr/data     : registered register-file write port
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_wren,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              pipe_stall,
  output logic              rf_wren,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_e;

  localparam logic [CNT_W-1:0] MaxWait = CNT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rf_wren_q, rf_wren_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic wb_live, in_stall, xfer;

  // Writes to r0 are architectural no-ops, so they leave the port free.
  assign wb_live = wb_wren && (wb_rd != '0);

`ifdef WB_STARVE_GUARD_EN
  assign in_stall = (state_q == STALL);
`else
  assign in_stall = 1'b0;
`endif

  always_comb begin
    mdu_ready  = 1'b0;
    pipe_stall = 1'b0;
    if (!reset) begin
      if (in_stall) begin
        mdu_ready  = 1'b1;
        pipe_stall = 1'b1;
      end else begin
        mdu_ready  = !wb_live;
      end
    end
  end

  assign xfer = mdu_valid && mdu_ready;

  // Next-state and wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (mdu_valid && wb_live) begin
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      WAIT: begin
        // A dropped mdu_valid is tolerated and simply abandons the wait.
        if (!mdu_valid || xfer) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < MaxWait) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
`ifdef WB_STARVE_GUARD_EN
          state_d    = STALL;
`else
          wait_cnt_d = MaxWait;
`endif
        end
      end
`ifdef WB_STARVE_GUARD_EN
      STALL: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
`endif
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Commit selection. In STALL the WB inputs are ignored; the pipeline
  // re-presents them next cycle, so they commit exactly once.
  always_comb begin
    rf_wren_d = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (!in_stall && wb_live) begin
      rf_wren_d = 1'b1;
      rf_addr_d = wb_rd;
      rf_data_d = wb_data;
    end else if (xfer) begin
      // r0-destined MDU results are accepted but dropped.
      rf_wren_d = (mdu_rd != '0);
      rf_addr_d = mdu_rd;
      rf_data_d = mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rf_wren_q  <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_wren_q  <= rf_wren_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign rf_wren = rf_wren_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: every expected register-file write
// is queued with the cycle it must appear in; a negedge monitor pops and
// compares, and also flags unexpected or missing writes.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_wren;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready, pipe_stall, rf_wren;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  wb_port_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_wren(wb_wren), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .rf_wren(rf_wren), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs change just after the rising edge; they are sampled at the next one.
  task automatic set_in(input logic ww, input logic [4:0] wr, input logic [31:0] wd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
    @(posedge clk); #1;
    wb_wren = ww; wb_rd = wr; wb_data = wd;
    mdu_valid = mv; mdu_rd = mr; mdu_data = md;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  // Monitor: a write must match the head of the scoreboard in cycle, addr, data.
  always @(negedge clk) begin
    exp_t e;
    if (rf_wren === 1'b1) begin
      if (sb.size() == 0) begin
        check("rf_unexpected", {59'd0, rf_addr}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("rf_cyc",  64'(cyc), 64'(e.cyc));
        check("rf_addr", {59'd0, rf_addr}, {59'd0, e.a});
        check("rf_data", {32'd0, rf_data}, {32'd0, e.d});
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("rf_missing", {63'd0, rf_wren}, 64'd1);
    end
  end

  initial begin
    reset = 1'b1;
    wb_wren = 1'b0; wb_rd = '0; wb_data = '0;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, mdu_ready}, 64'd0);
    check("rst_stall", {63'd0, pipe_stall}, 64'd0);
    check("rst_wren",  {63'd0, rf_wren}, 64'd0);
    check("rst_addr",  {59'd0, rf_addr}, 64'd0);
    check("rst_data",  {32'd0, rf_data}, 64'd0);
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Idle pipe: MDU served immediately.
    set_in(0, 0, 0, 1, 7, 32'hDEADBEEF);
    push(7, 32'hDEADBEEF);
    @(negedge clk);
    check("idle_ready", {63'd0, mdu_ready}, 64'd1);
    check("idle_stall", {63'd0, pipe_stall}, 64'd0);
    set_in(0, 0, 0, 0, 0, 0);

    // Collision: WB wins, MDU served on the following free cycle.
    set_in(1, 3, 32'h11, 1, 4, 32'h44);
    push(3, 32'h11);
    @(negedge clk);
    check("col_ready0", {63'd0, mdu_ready}, 64'd0);
    set_in(0, 0, 0, 1, 4, 32'h44);
    push(4, 32'h44);
    @(negedge clk);
    check("col_ready1", {63'd0, mdu_ready}, 64'd1);
    set_in(0, 0, 0, 0, 0, 0);

    // r0 targets: MDU accepted, nothing written.
    set_in(1, 0, 32'h55, 1, 0, 32'h66);
    @(negedge clk);
    check("r0_ready", {63'd0, mdu_ready}, 64'd1);
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r0_wren", {63'd0, rf_wren}, 64'd0);

`ifdef WB_STARVE_GUARD_EN
    // Starvation: 1 IDLE + 4 WAIT blocked cycles, then one STALL cycle.
    for (int i = 0; i < 6; i++) begin
      set_in(1, 9, 32'hA0 + 32'(i), 1, 12, 32'hC3);
      if (i < 5) push(9, 32'hA0 + 32'(i));
      else       push(12, 32'hC3);
      @(negedge clk);
      check("stv_ready", {63'd0, mdu_ready}, (i == 5) ? 64'd1 : 64'd0);
      check("stv_stall", {63'd0, pipe_stall}, (i == 5) ? 64'd1 : 64'd0);
    end
    // Held WB write re-presented after the stall commits exactly once.
    set_in(1, 9, 32'hA5, 0, 0, 0);
    push(9, 32'hA5);
    @(negedge clk);
    check("held_stall", {63'd0, pipe_stall}, 64'd0);
`else
    // Guard off: MDU starves for the whole WB burst, never a stall.
    for (int i = 0; i < 10; i++) begin
      set_in(1, 9, 32'hB0 + 32'(i), 1, 12, 32'hC3);
      push(9, 32'hB0 + 32'(i));
      @(negedge clk);
      check("nog_ready", {63'd0, mdu_ready}, 64'd0);
      check("nog_stall", {63'd0, pipe_stall}, 64'd0);
    end
    set_in(0, 0, 0, 1, 12, 32'hC3);
    push(12, 32'hC3);
    @(negedge clk);
    check("nog_free_ready", {63'd0, mdu_ready}, 64'd1);
`endif
    set_in(0, 0, 0, 0, 0, 0);

    // Reset while waiting (wait_cnt = 2): grant dropped, MDU served after.
    set_in(1, 5, 32'h50, 1, 6, 32'h77);
    push(5, 32'h50);
    set_in(1, 5, 32'h51, 1, 6, 32'h77);
    push(5, 32'h51);
    set_in(0, 0, 0, 1, 6, 32'h77);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_ready", {63'd0, mdu_ready}, 64'd0);
    check("rstw_stall", {63'd0, pipe_stall}, 64'd0);
    set_in(0, 0, 0, 1, 6, 32'h77);
    reset = 1'b0;
    push(6, 32'h77);
    @(negedge clk);
    check("rstw_wren",   {63'd0, rf_wren}, 64'd0);
    check("rstw_addr",   {59'd0, rf_addr}, 64'd0);
    check("rstw_stall2", {63'd0, pipe_stall}, 64'd0);
    check("rstw_ready2", {63'd0, mdu_ready}, 64'd1);
    set_in(0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
